// File: rtl/lectura_rtc.sv
// lectura_rtc: read-side bus engine for a parallel multiplexed AD/CS/RD/WR RTC.
// Issues the transfer command, reads NREG consecutive registers into shadow
// storage and, only once the whole sweep finished, copies them to the snapshot
// outputs so the display never sees a torn time/date.
//
// Ports:
//   clk, rst (async, active-low)   clocking / reset
//   en          bus grant from the arbiter; sampled at start and at phase ends
//   start       one-cycle sweep request (ignored while busy)
//   data_in     RTC read data
//   addr_out    address/command driven while bus_oe=1
//   bus_oe, AD, CS, RD, WR          bus controls (AD: 0=address, strobes active-low)
//   seg..anio   snapshot of registers BASE_ADDR+0..+5
//   busy        sweep in progress
//   done        one-cycle pulse when the snapshot updates
module lectura_rtc #(
  parameter int unsigned PH_SET    = 2,
  parameter int unsigned PH_ACT    = 6,
  parameter int unsigned PH_HOLD   = 2,
  parameter logic [7:0]  CMD       = 8'hF0,
  parameter logic [7:0]  BASE_ADDR = 8'h21,
  parameter int unsigned NREG      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic [7:0] addr_out,
  output logic       bus_oe,
  output logic       AD,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic       busy,
  output logic       done
);

  localparam int unsigned NBuf = (NREG > 6) ? NREG : 6;
  localparam int unsigned IdxW = $clog2(NBuf);

  localparam logic [7:0]      SetLoad  = 8'(PH_SET - 1);
  localparam logic [7:0]      ActLoad  = 8'(PH_ACT - 1);
  localparam logic [7:0]      HoldLoad = 8'(PH_HOLD - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NREG - 1);

  typedef enum logic [2:0] {StIdle, StCmdAddr, StRegAddr, StRegRead, StDone} state_e;
  typedef enum logic [1:0] {SubSet, SubAct, SubHold} sub_e;

  state_e          state_q, state_d;
  sub_e            sub_q, sub_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic [7:0] shadow_q [NBuf];
  logic [7:0] snap_q   [6];

  logic [7:0] addr_q, addr_d;
  logic       oe_q, oe_d, ad_q, ad_d, cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic       sample, load_snap;
  logic       in_addr, in_bus, act;

  // Next-state: one down-counter walks SET -> ACT -> HOLD; phase decisions at HOLD end.
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start && en) begin
          state_d = StCmdAddr;
          sub_d   = SubSet;
          cnt_d   = SetLoad;
          idx_d   = '0;
        end
      end
      default: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          unique case (sub_q)
            SubSet: begin
              sub_d = SubAct;
              cnt_d = ActLoad;
            end
            SubAct: begin
              sub_d = SubHold;
              cnt_d = HoldLoad;
            end
            default: begin
              sub_d = SubSet;
              cnt_d = SetLoad;
              if (!en) begin
                // Grant lost: finish cleanly and drop the partial sweep.
                state_d = StIdle;
              end else begin
                case (state_q)
                  StCmdAddr: begin
                    state_d = StRegAddr;
                    idx_d   = '0;
                  end
                  StRegAddr: state_d = StRegRead;
                  default: begin
                    if (idx_q == LastIdx) begin
                      state_d = StDone;
                    end else begin
                      idx_d   = idx_q + IdxW'(1);
                      state_d = StRegAddr;
                    end
                  end
                endcase
              end
            end
          endcase
        end
      end
    endcase
  end

  assign sample    = (state_q == StRegRead) && (sub_q == SubAct) && (cnt_q == 8'd0);
  assign load_snap = (state_q == StRegRead) && (state_d == StDone);

  // Bus outputs are registered from the next state so they line up with state_q.
  always_comb begin
    in_addr = (state_d == StCmdAddr) || (state_d == StRegAddr);
    in_bus  = in_addr || (state_d == StRegRead);
    act     = in_bus && (sub_d == SubAct);
    addr_d  = 8'h00;
    if (state_d == StCmdAddr)      addr_d = CMD;
    else if (state_d == StRegAddr) addr_d = BASE_ADDR + 8'(idx_d);
    oe_d   = in_addr;
    ad_d   = !in_addr;
    cs_d   = !act;
    wr_d   = !(act && in_addr);
    rd_d   = !(act && (state_d == StRegRead));
    busy_d = in_bus;
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      sub_q   <= SubSet;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      addr_q  <= 8'h00;
      oe_q    <= 1'b0;
      ad_q    <= 1'b1;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      oe_q    <= oe_d;
      ad_q    <= ad_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(NBuf); k++) shadow_q[k] <= 8'h00;
      for (int k = 0; k < 6; k++) snap_q[k] <= 8'h00;
    end else begin
      if (sample) shadow_q[idx_q] <= data_in;
      if (load_snap) begin
        for (int k = 0; k < 6; k++) snap_q[k] <= shadow_q[k];
      end
    end
  end

  assign addr_out = addr_q;
  assign bus_oe   = oe_q;
  assign AD       = ad_q;
  assign CS       = cs_q;
  assign RD       = rd_q;
  assign WR       = wr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign seg      = snap_q[0];
  assign min      = snap_q[1];
  assign hora     = snap_q[2];
  assign dia      = snap_q[3];
  assign mes      = snap_q[4];
  assign anio     = snap_q[5];

endmodule

// File: tb/tb_lectura_rtc.sv
// Directed bench for lectura_rtc with a small RTC register model and a bus-protocol monitor.
module tb_lectura_rtc;

  logic       clk = 1'b0;
  logic       rst, en, start;
  logic [7:0] data_in;
  logic [7:0] addr_out;
  logic       bus_oe, AD, CS, RD, WR, busy, done;
  logic [7:0] seg, min, hora, dia, mes, anio;

  int n_checks = 0;
  int n_fail   = 0;

  lectura_rtc dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .data_in(data_in),
    .addr_out(addr_out), .bus_oe(bus_oe), .AD(AD), .CS(CS), .RD(RD), .WR(WR),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RTC model: latches the address strobed with WR, returns the stored byte.
  logic [7:0] rtc_mem [6];
  logic [7:0] rtc_addr = 8'h00;
  logic [2:0] ridx;
  assign ridx    = 3'(rtc_addr - 8'h21);
  assign data_in = (rtc_addr >= 8'h21 && rtc_addr <= 8'h26) ? rtc_mem[ridx] : 8'hFF;

  always @(negedge clk)
    if (rst && !CS && !WR && !AD && bus_oe) rtc_addr <= addr_out;

  // Bus monitor.
  int         run = 0, viol = 0, cs_pulses = 0, rd_pulses = 0, wr_cnt = 0;
  logic       wr_prev = 1'b1, rd_prev = 1'b1;
  logic [7:0] wr_addr [64];

  always @(negedge clk) begin
    automatic int v = 0;
    if (!rst) begin
      run     <= 0;
      wr_prev <= 1'b1;
      rd_prev <= 1'b1;
    end else begin
      if (!CS) run <= run + 1;
      else begin
        if (run != 0) begin
          cs_pulses <= cs_pulses + 1;
          if (run != 6) v++;
        end
        run <= 0;
      end
      if (!RD && !WR) v++;
      if (!RD && bus_oe) v++;
      if (!AD && !bus_oe) v++;
      if (CS && (!RD || !WR)) v++;
      viol <= viol + v;
      if (!WR && wr_prev) begin
        wr_addr[wr_cnt[5:0]] <= addr_out;
        wr_cnt <= wr_cnt + 1;
      end
      if (!RD && rd_prev) rd_pulses <= rd_pulses + 1;
      wr_prev <= WR;
      rd_prev <= RD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input logic [47:0] v);
    for (int k = 0; k < 6; k++) rtc_mem[k] = v[47-8*k -: 8];
  endtask

  task automatic chk_snap(input string tag, input logic [47:0] v);
    chk({tag, ".seg"},  seg,  v[47:40]);
    chk({tag, ".min"},  min,  v[39:32]);
    chk({tag, ".hora"}, hora, v[31:24]);
    chk({tag, ".dia"},  dia,  v[23:16]);
    chk({tag, ".mes"},  mes,  v[15:8]);
    chk({tag, ".anio"}, anio, v[7:0]);
  endtask

  // One sweep from a start pulse; optional stray starts at t0+5 and t0+129.
  task automatic sweep(input bit extra, output int done_cyc, output int ndone,
                       output logic b1, output logic b130, output logic b131);
    @(negedge clk);
    start = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    done_cyc = 0;
    ndone    = 0;
    b1 = 1'bx; b130 = 1'bx; b131 = 1'bx;
    for (int c = 1; c <= 180; c++) begin
      if (c == 1)   b1   = busy;
      if (c == 130) b130 = busy;
      if (c == 131) b131 = busy;
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc == 0) done_cyc = c;
      end
      start = extra && (c == 5 || c == 129);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  localparam logic [47:0] MemA = 48'h45_30_12_28_05_16;
  localparam logic [47:0] MemB = 48'h59_07_23_31_12_99;

  int   dc, nd, wbase, rbase, cbase;
  logic b1, b130, b131, b90, b91;

  initial begin
    rst = 1'b0; en = 1'b1; start = 1'b1;
    set_mem(MemA);
    repeat (4) @(negedge clk);
    chk("rst.AD", AD, 1'b1);
    chk("rst.CS", CS, 1'b1);
    chk("rst.RD", RD, 1'b1);
    chk("rst.WR", WR, 1'b1);
    chk("rst.bus_oe", bus_oe, 1'b0);
    chk("rst.addr_out", addr_out, 8'h00);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk_snap("rst", 48'h0);
    chk("rst.wr_cnt", wr_cnt, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Nominal sweep.
    wbase = wr_cnt; rbase = rd_pulses; cbase = cs_pulses;
    sweep(1'b0, dc, nd, b1, b130, b131);
    chk("nom.done_cycle", dc, 131);
    chk("nom.done_count", nd, 1);
    chk("nom.busy_t1", b1, 1'b1);
    chk("nom.busy_t130", b130, 1'b1);
    chk("nom.busy_t131", b131, 1'b0);
    chk("nom.wr_pulses", wr_cnt - wbase, 7);
    chk("nom.first_addr", wr_addr[wbase[5:0]], 8'hF0);
    chk("nom.addr1", wr_addr[6'(wbase + 1)], 8'h21);
    chk("nom.addr6", wr_addr[6'(wbase + 6)], 8'h26);
    chk("nom.rd_pulses", rd_pulses - rbase, 6);
    chk("nom.cs_pulses", cs_pulses - cbase, 13);
    chk_snap("nom", MemA);

    // start with en=0 is ignored.
    cbase = cs_pulses;
    @(negedge clk);
    start = 1'b1; en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("noen.busy", busy, 1'b0);
    repeat (10) @(negedge clk);
    chk("noen.busy_later", busy, 1'b0);
    chk("noen.cs_pulses", cs_pulses - cbase, 0);

    // Abort: en drops during the 4th read phase (cycles 81..90).
    set_mem(MemB);
    wbase = wr_cnt; rbase = rd_pulses;
    nd = 0;
    @(negedge clk);
    start = 1'b1; en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      if (c == 85) en = 1'b0;
      if (c == 90) b90 = busy;
      if (c == 91) b91 = busy;
      if (done === 1'b1) nd++;
      @(negedge clk);
    end
    chk("abort.busy_hold", b90, 1'b1);
    chk("abort.busy_after", b91, 1'b0);
    chk("abort.done_count", nd, 0);
    chk("abort.rd_pulses", rd_pulses - rbase, 4);
    chk("abort.wr_pulses", wr_cnt - wbase, 5);
    chk_snap("abort", MemA);

    // Restart after abort.
    sweep(1'b0, dc, nd, b1, b130, b131);
    chk("restart.done_cycle", dc, 131);
    chk("restart.done_count", nd, 1);
    chk_snap("restart", MemB);

    // Stray starts during a sweep.
    set_mem(MemA);
    sweep(1'b1, dc, nd, b1, b130, b131);
    chk("stray.done_cycle", dc, 131);
    chk("stray.done_count", nd, 1);
    chk("stray.busy_t131", b131, 1'b0);
    chk_snap("stray", MemA);

    // Async reset during ACT of the first read phase (cycles 23..28).
    @(negedge clk);
    start = 1'b1; en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    chk("arst.CS_before", CS, 1'b0);
    chk("arst.RD_before", RD, 1'b0);
    #3 rst = 1'b0;
    #1;
    chk("arst.CS", CS, 1'b1);
    chk("arst.RD", RD, 1'b1);
    chk("arst.busy", busy, 1'b0);
    chk_snap("arst", 48'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    set_mem(MemB);
    sweep(1'b0, dc, nd, b1, b130, b131);
    chk("post_rst.done_cycle", dc, 131);
    chk_snap("post_rst", MemB);

    chk("bus.protocol_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lectura_rtc.md
# lectura_rtc

Read-side bus engine for the parallel multiplexed-address/data RTC. It is the counterpart of the write path: it issues the transfer command, then reads six time/date registers (seconds through year) over the same active-low AD/CS/RD/WR bus. It presents them to the display/VGA logic as a coherent snapshot. It sits beside the write controller; the top-level arbiter grants the bus to only one of them at a time, using `en`.

## Interface

Parameters:
- `PH_SET`, default 2: cycles of setup per bus phase (address/AD valid, strobes high).
- `PH_ACT`, default 6: cycles CS and strobe are held low per phase.
- `PH_HOLD`, default 2: cycles of hold after strobe release (AD/address still valid).
- `CMD`, default 8'hF0: transfer command issued before reading.
- `BASE_ADDR`, default 8'h21: address of the first (seconds) register.
- `NREG`, default 6: registers read, at consecutive addresses from BASE_ADDR.

Ports:
- `clk`  in  1  system clock; only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  bus grant; operations start only with en=1.
- `start`  in  1  one-cycle request for a read sweep.
- `data_in`  in  8  RTC bus read value.
- `addr_out`  out  8  value driven on bus during address phases.
- `bus_oe`  out  1  1 = drive addr_out onto bus.
- `AD`  out  1  0 = address phase, 1 = data phase.
- `CS`  out  1  chip select, active-low.
- `RD`  out  1  read strobe, active-low.
- `WR`  out  1  write strobe, active-low.
- `seg`, `min`, `hora`, `dia`, `mes`, `anio`  out  8 each  snapshot of registers BASE_ADDR+0..+5 (BCD as stored in the RTC).
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse: snapshot updated.

## Operation

- Reset values: AD=1, CS=1, RD=1, WR=1, bus_oe=0, addr_out=0, all snapshot registers 0, busy=0, done=0.
- States: IDLE, CMD_ADDR, REG_ADDR, REG_READ, DONE.
- Each bus phase has three sub-steps: SET (PH_SET cycles), ACT (PH_ACT cycles), HOLD (PH_HOLD cycles). A single down-counter sequences the sub-steps.
- **IDLE:** `start`=1 and `en`=1 at an edge moves the FSM to CMD_ADDR. `start` with `en`=0 is ignored.
- **CMD_ADDR:**
  - addr_out=CMD, bus_oe=1, AD=0 for the whole phase.
  - CS=0 and WR=0 during ACT only.
  - Then go to REG_ADDR with index i=0.
- **REG_ADDR:**
  - addr_out=BASE_ADDR+i, bus_oe=1, AD=0.
  - CS=0 and WR=0 during ACT.
  - Then go to REG_READ.
- **REG_READ:**
  - bus_oe=0, AD=1; CS=0 and RD=0 during ACT.
  - data_in is sampled into shadow[i] at the edge ending the last ACT cycle.
  - After HOLD: if i=NREG-1, go to DONE; else i+1 and go to REG_ADDR.
- **DONE:** copy all shadow registers to the outputs in the same edge; done=1 for one cycle; return to IDLE.
- Outputs change only in DONE, so the snapshot is never torn.
- WR and RD are never low in the same cycle. CS is high in all SET and HOLD cycles.
- `start` while busy=1 is ignored. It is not queued.
- `en` falls mid-sweep: the current phase completes through HOLD, then the FSM goes to IDLE. There is no done pulse, the outputs are unchanged, and the shadow contents are discarded.
- `rst` asserted mid-sweep: all outputs go to reset values immediately, asynchronously. The bus strobes release within the same cycle.

## Timing

- Phase length L = PH_SET+PH_ACT+PH_HOLD = 10 cycles by default.
- A sweep is 1+2·NREG = 13 phases = 130 cycles.
- With `start` sampled at edge t0:
  - busy=1 from t0+1 through t0+130.
  - First SET cycle is t0+1.
  - done=1 and the new outputs are visible in cycle t0+131. busy=0 in that cycle.
- Earliest accepted restart: a `start` sampled at the edge ending the done cycle.
- Read sample point: the last cycle of ACT, i.e. cycle PH_SET+PH_ACT of the read phase, counting from 1.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan

- **Reset:** hold rst=0 with start=1 and en=1 → AD=CS=RD=WR=1, bus_oe=0, busy=0, all snapshot registers 0, no bus activity.
- **Nominal sweep:**
  - Stimulus: RTC model returns 8'h45, 8'h30, 8'h12, 8'h28, 8'h05, 8'h16 for addresses 21..26.
  - Required: start at t0 → first WR pulse carries address F0; six address/read pairs follow; done only at t0+131.
  - Required snapshot: seg=45, min=30, hora=12, dia=28, mes=05, anio=16.
- **Bus checker across the sweep:** CS low exactly 6 cycles per phase; never RD=0 and WR=0 together; bus_oe=0 whenever RD=0; AD=0 only with bus_oe=1.
- **Abort:**
  - Stimulus: drop en during the 4th read phase.
  - Required: the phase finishes its HOLD, then IDLE; no done; outputs keep the prior snapshot; a new start with en=1 completes normally in 130 cycles.
- **Start handling:**
  - Stimulus: start pulses at t0+5 and t0+129 during a sweep.
  - Required: both ignored, exactly one done.
  - Stimulus: start with en=0.
  - Required: stays IDLE.
- **Async reset mid-ACT of a read phase:** CS and RD return high in the same cycle; the snapshot clears to 0; the next sweep after release is correct.
